// File: rtl/jt12_eg_rate_step.sv
// jt12_eg_rate_step
// Upstream stage of the envelope-generator attenuation step. It holds the
// global EG counter with its divide-by-3 sample prescaler. For each operator
// slot it forms the effective 6-bit rate from the base rate plus key scaling,
// and from that rate and the counter it derives step and sum_up.
// The slot path is a two-stage pipeline that advances only on clk_en.
// Optional build macro: JT12_EG_FAST_CNT_EN bypasses the prescaler, so the
// counter advances on every sample. It is used only to shorten simulations.
module jt12_eg_rate_step #(
  parameter int CNT_W = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             zero,
  input  logic [4:0]       base_rate,
  input  logic [4:0]       keycode,
  input  logic [1:0]       ks,
  input  logic             attack_in,
  output logic [4:0]       rate,
  output logic             step,
  output logic             sum_up,
  output logic             attack,
  output logic [CNT_W-1:0] eg_cnt
);

  // Sample-rate bookkeeping
  logic [1:0] div3;
  logic       tick;

  // Stage-1 registers
  logic [5:0] r1_q;
  logic       attack_s1;

  // Stage-1 combinational terms
  logic [6:0] ks_add;
  logic [6:0] r1_sum;
  logic [5:0] r1_next;

  // Stage-2 combinational terms
  logic [3:0] sh;
  logic [2:0] sel;
  logic       aligned;
  logic [7:0] row;
  logic       rate_nz;
  logic       step_next;
  logic       sum_up_next;

  // The counter advances once every three samples, or on every sample in the fast build
  always_ff @(posedge clk) begin
    if (rst) begin
      div3   <= 2'd0;
      tick   <= 1'b0;
      eg_cnt <= '0;
    end else if (clk_en && zero) begin
`ifdef JT12_EG_FAST_CNT_EN
      div3   <= 2'd0;
      tick   <= 1'b1;
      eg_cnt <= eg_cnt + 1'b1;
`else
      if (div3 == 2'd2) begin
        div3   <= 2'd0;
        tick   <= 1'b1;
        eg_cnt <= eg_cnt + 1'b1;
      end else begin
        div3   <= div3 + 2'd1;
        tick   <= 1'b0;
      end
`endif
    end
  end

  // Effective rate: base rate doubled plus the keycode scaled by ks, saturated at 63
  always_comb begin
    ks_add  = {2'b00, keycode >> (2'd3 - ks)};
    r1_sum  = {1'b0, base_rate, 1'b0} + ks_add;
    r1_next = 6'd0;
    if (base_rate != 5'd0) begin
      if (r1_sum > 7'd63) r1_next = 6'd63;
      else                r1_next = r1_sum[5:0];
    end
  end

  // Stage 1 captures the effective rate and attack flag for the current slot
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_q      <= 6'd0;
      attack_s1 <= 1'b0;
    end else if (clk_en) begin
      r1_q      <= r1_next;
      attack_s1 <= attack_in;
    end
  end

  // The high rate bits pick which counter window is used; the low bits pick the step pattern
  always_comb begin
    if (r1_q[5:2] >= 4'd12) sh = 4'd0;
    else                    sh = 4'd11 - r1_q[5:2];
    sel     = eg_cnt[sh +: 3];
    aligned = ((eg_cnt & ~({CNT_W{1'b1}} << sh)) == '0);
    case (r1_q[1:0])
      2'b00:   row = 8'b1010_1010;
      2'b01:   row = 8'b1110_1010;
      2'b10:   row = 8'b1110_1110;
      default: row = 8'b1111_1110;
    endcase
    rate_nz     = (r1_q[5:1] != 5'd0);
    step_next   = rate_nz & row[sel];
    sum_up_next = tick & aligned & rate_nz;
  end

  // Stage 2 registers the outputs and uses the counter value from before any same-edge increment
  always_ff @(posedge clk) begin
    if (rst) begin
      rate   <= 5'd0;
      step   <= 1'b0;
      sum_up <= 1'b0;
      attack <= 1'b0;
    end else if (clk_en) begin
      rate   <= r1_q[5:1];
      step   <= step_next;
      sum_up <= sum_up_next;
      attack <= attack_s1;
    end
  end

endmodule
